// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard unit.
// The master modport is the pipeline side; the slave modport is the hazard unit.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       rn_id;
    logic [3:0]       rm_id;
    logic [3:0]       rd_id;
    logic             use_rn;
    logic             use_rm;
    logic             use_rd;
    logic [3:0]       rd_ex;
    logic [3:0]       rd_mem;
    logic [3:0]       rd_wb;
    logic             rf_ex;
    logic             rf_mem;
    logic             rf_wb;
    logic             load_ex;
    logic             branch_taken;
    logic             mem_busy;
    logic             clr_stats;

    logic             nop_sel;
    logic             pc_le;
    logic             ifid_le;
    logic             pipe_le;
    logic             ifid_clr;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       fwd_c;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rn_id, rm_id, rd_id, use_rn, use_rm, use_rd,
        output rd_ex, rd_mem, rd_wb, rf_ex, rf_mem, rf_wb,
        output load_ex, branch_taken, mem_busy, clr_stats,
        input  nop_sel, pc_le, ifid_le, pipe_le, ifid_clr,
        input  fwd_a, fwd_b, fwd_c, stall_cnt, flush_cnt
    );

    modport slave (
        input  rn_id, rm_id, rd_id, use_rn, use_rm, use_rd,
        input  rd_ex, rd_mem, rd_wb, rf_ex, rf_mem, rf_wb,
        input  load_ex, branch_taken, mem_busy, clr_stats,
        output nop_sel, pc_le, ifid_le, pipe_le, ifid_clr,
        output fwd_a, fwd_b, fwd_c, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller and operand-forwarding select for the five-stage pipeline,
// with saturating stall and flush statistics.
module hazard_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hif
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [2:0]       FCNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       fcnt;
    logic [2:0]       fcnt_nxt;
    logic             lu;
    logic             ex_fwd_en;
    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       used,
        input logic       ex_en,
        input logic [3:0] ex_rd,
        input logic       mem_en,
        input logic [3:0] mem_rd,
        input logic       wb_en,
        input logic [3:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != 4'd15) begin
            if (ex_en && ex_rd == src)        sel = 2'b01;
            else if (mem_en && mem_rd == src) sel = 2'b10;
            else if (wb_en && wb_rd == src)   sel = 2'b11;
        end
        return sel;
    endfunction

    // A load result is not available in EX, so EX forwarding is only for ALU results.
    assign ex_fwd_en = hif.rf_ex & ~hif.load_ex;

    assign lu = hif.load_ex & hif.rf_ex & (hif.rd_ex != 4'd15) &
                ((hif.use_rn & (hif.rn_id == hif.rd_ex)) |
                 (hif.use_rm & (hif.rm_id == hif.rd_ex)) |
                 (hif.use_rd & (hif.rd_id == hif.rd_ex)));

    assign hif.fwd_a = rst_n ? fwd_sel(hif.rn_id, hif.use_rn, ex_fwd_en, hif.rd_ex,
                                       hif.rf_mem, hif.rd_mem, hif.rf_wb, hif.rd_wb) : 2'b00;
    assign hif.fwd_b = rst_n ? fwd_sel(hif.rm_id, hif.use_rm, ex_fwd_en, hif.rd_ex,
                                       hif.rf_mem, hif.rd_mem, hif.rf_wb, hif.rd_wb) : 2'b00;
    assign hif.fwd_c = rst_n ? fwd_sel(hif.rd_id, hif.use_rd, ex_fwd_en, hif.rd_ex,
                                       hif.rf_mem, hif.rd_mem, hif.rf_wb, hif.rd_wb) : 2'b00;

    assign hif.stall_cnt = stall_q;
    assign hif.flush_cnt = flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // FLUSH with fcnt==0 is the last squashed cycle, so the total squash is fcnt+2 cycles.
    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        hif.nop_sel  = 1'b0;
        hif.ifid_clr = 1'b0;
        hif.pc_le    = 1'b1;
        hif.ifid_le  = 1'b1;
        hif.pipe_le  = 1'b1;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        if (!rst_n) begin
            hif.nop_sel  = 1'b1;
            hif.ifid_clr = 1'b1;
            hif.pc_le    = 1'b0;
            hif.ifid_le  = 1'b0;
        end else if (hif.mem_busy) begin
            hif.pc_le   = 1'b0;
            hif.ifid_le = 1'b0;
            hif.pipe_le = 1'b0;
        end else if (state == FLUSH) begin
            hif.nop_sel  = 1'b1;
            hif.ifid_clr = 1'b1;
            flush_evt    = 1'b1;
            if (fcnt == 3'd0) begin
                state_nxt = RUN;
            end else begin
                fcnt_nxt = fcnt - 3'd1;
            end
        end else if (hif.branch_taken) begin
            hif.nop_sel  = 1'b1;
            hif.ifid_clr = 1'b1;
            flush_evt    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                fcnt_nxt  = FCNT_INIT;
            end
        end else if (lu) begin
            hif.nop_sel = 1'b1;
            hif.pc_le   = 1'b0;
            hif.ifid_le = 1'b0;
            stall_evt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (hif.clr_stats) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != '1) stall_q <= stall_q + CNT_ONE;
            if (flush_evt && flush_q != '1) flush_q <= flush_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes model predictions into a queue,
// an independent negedge monitor pops and compares them against the DUT each cycle.
module tb_hazard_unit;

    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst_n;
        logic [3:0] rn_id, rm_id, rd_id;
        logic       use_rn, use_rm, use_rd;
        logic [3:0] rd_ex, rd_mem, rd_wb;
        logic       rf_ex, rf_mem, rf_wb;
        logic       load_ex, branch_taken, mem_busy, clr_stats;
    } stim_t;

    typedef struct {
        logic       nop_sel, pc_le, ifid_le, pipe_le, ifid_clr;
        logic [1:0] fwd_a, fwd_b, fwd_c;
        int         stall_cnt, flush_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_unit #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hif  (hif)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference state: squash cycles still owed after the current one, and plain counters.
    int   m_squash = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [3:0] src, input logic used, input stim_t s);
        logic [3:0] dst [3];
        logic       wr  [3];
        dst = '{s.rd_ex, s.rd_mem, s.rd_wb};
        wr  = '{s.rf_ex && !s.load_ex, s.rf_mem, s.rf_wb};
        if (!used || src == 4'd15) return 2'b00;
        for (int k = 0; k < 3; k++)
            if (wr[k] && dst[k] == src) return 2'(k + 1);
        return 2'b00;
    endfunction

    task automatic modelCycle(input stim_t s);
        exp_t e;
        bit   lu, freeze, bubble, stall;
        e.stall_cnt = m_stall;
        e.flush_cnt = m_flush;
        if (!s.rst_n) begin
            m_squash = 0; m_stall = 0; m_flush = 0;
            e = '{nop_sel: 1, pc_le: 0, ifid_le: 0, pipe_le: 1, ifid_clr: 1,
                  fwd_a: 0, fwd_b: 0, fwd_c: 0, stall_cnt: 0, flush_cnt: 0};
        end else begin
            lu = s.load_ex && s.rf_ex && s.rd_ex != 4'd15 &&
                 ((s.use_rn && s.rn_id == s.rd_ex) || (s.use_rm && s.rm_id == s.rd_ex) ||
                  (s.use_rd && s.rd_id == s.rd_ex));
            freeze = 0; bubble = 0; stall = 0;
            if (s.mem_busy) freeze = 1;
            else if (m_squash > 0) begin bubble = 1; m_squash--; end
            else if (s.branch_taken) begin bubble = 1; m_squash = FLUSH_CYCLES - 1; end
            else if (lu) stall = 1;
            e.nop_sel  = bubble || stall;
            e.ifid_clr = bubble;
            e.pc_le    = !freeze && !stall;
            e.ifid_le  = !freeze && !stall;
            e.pipe_le  = !freeze;
            e.fwd_a    = refFwd(s.rn_id, s.use_rn, s);
            e.fwd_b    = refFwd(s.rm_id, s.use_rm, s);
            e.fwd_c    = refFwd(s.rd_id, s.use_rd, s);
            if (s.clr_stats) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (stall)  m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
                if (bubble) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            end
        end
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        cyc++;
        rst_n            = s.rst_n;
        hif.rn_id        = s.rn_id;
        hif.rm_id        = s.rm_id;
        hif.rd_id        = s.rd_id;
        hif.use_rn       = s.use_rn;
        hif.use_rm       = s.use_rm;
        hif.use_rd       = s.use_rd;
        hif.rd_ex        = s.rd_ex;
        hif.rd_mem       = s.rd_mem;
        hif.rd_wb        = s.rd_wb;
        hif.rf_ex        = s.rf_ex;
        hif.rf_mem       = s.rf_mem;
        hif.rf_wb        = s.rf_wb;
        hif.load_ex      = s.load_ex;
        hif.branch_taken = s.branch_taken;
        hif.mem_busy     = s.mem_busy;
        hif.clr_stats    = s.clr_stats;
        modelCycle(s);
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{rst_n: 1, rn_id: 0, rm_id: 0, rd_id: 0, use_rn: 0, use_rm: 0, use_rd: 0,
              rd_ex: 0, rd_mem: 0, rd_wb: 0, rf_ex: 0, rf_mem: 0, rf_wb: 0,
              load_ex: 0, branch_taken: 0, mem_busy: 0, clr_stats: 0};
        return s;
    endfunction

    // Small register pool (plus r15) so matches and hazards are frequent.
    function automatic logic [3:0] pickReg();
        int r;
        r = $urandom_range(5);
        return (r == 5) ? 4'd15 : 4'(r);
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rst_n        = ($urandom_range(63) != 0);
        s.rn_id        = pickReg();
        s.rm_id        = pickReg();
        s.rd_id        = pickReg();
        s.use_rn       = 1'($urandom_range(1));
        s.use_rm       = 1'($urandom_range(1));
        s.use_rd       = 1'($urandom_range(1));
        s.rd_ex        = pickReg();
        s.rd_mem       = pickReg();
        s.rd_wb        = pickReg();
        s.rf_ex        = 1'($urandom_range(1));
        s.rf_mem       = 1'($urandom_range(1));
        s.rf_wb        = 1'($urandom_range(1));
        s.load_ex      = 1'($urandom_range(1));
        s.branch_taken = ($urandom_range(11) == 0);
        s.mem_busy     = ($urandom_range(5) == 0);
        s.clr_stats    = ($urandom_range(40) == 0);
        return s;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("nop_sel",   32'(hif.nop_sel),   32'(mon_e.nop_sel));
            checkOutput("ifid_clr",  32'(hif.ifid_clr),  32'(mon_e.ifid_clr));
            checkOutput("pc_le",     32'(hif.pc_le),     32'(mon_e.pc_le));
            checkOutput("ifid_le",   32'(hif.ifid_le),   32'(mon_e.ifid_le));
            checkOutput("pipe_le",   32'(hif.pipe_le),   32'(mon_e.pipe_le));
            checkOutput("fwd_a",     32'(hif.fwd_a),     32'(mon_e.fwd_a));
            checkOutput("fwd_b",     32'(hif.fwd_b),     32'(mon_e.fwd_b));
            checkOutput("fwd_c",     32'(hif.fwd_c),     32'(mon_e.fwd_c));
            checkOutput("stall_cnt", 32'(hif.stall_cnt), 32'(mon_e.stall_cnt));
            checkOutput("flush_cnt", 32'(hif.flush_cnt), 32'(mon_e.flush_cnt));
        end
    end

    initial begin
        stim_t s;
        s = idleStim();
        s.rst_n = 0;
        hif.rn_id = 0; hif.rm_id = 0; hif.rd_id = 0;
        hif.use_rn = 0; hif.use_rm = 0; hif.use_rd = 0;
        hif.rd_ex = 0; hif.rd_mem = 0; hif.rd_wb = 0;
        hif.rf_ex = 0; hif.rf_mem = 0; hif.rf_wb = 0;
        hif.load_ex = 0; hif.branch_taken = 0; hif.mem_busy = 0; hif.clr_stats = 0;
        repeat (2) applyStimulus(s);
        s = idleStim();
        repeat (2) applyStimulus(s);

        s.load_ex = 1; s.rf_ex = 1; s.rd_ex = 3; s.rn_id = 3; s.use_rn = 1;
        applyStimulus(s);
        s = idleStim();
        s.rd_mem = 3; s.rf_mem = 1; s.rn_id = 3; s.use_rn = 1;
        applyStimulus(s);

        s = idleStim();
        s.rd_ex = 5; s.rd_mem = 5; s.rd_wb = 5; s.rf_ex = 1; s.rf_mem = 1; s.rf_wb = 1;
        s.rm_id = 5; s.use_rm = 1;
        applyStimulus(s);
        s.rf_ex = 0;   applyStimulus(s);
        s.rf_mem = 0;  applyStimulus(s);
        s.rm_id = 15;  applyStimulus(s);

        s = idleStim();
        s.branch_taken = 1; applyStimulus(s);
        s.branch_taken = 0; repeat (4) applyStimulus(s);

        s.branch_taken = 1; s.load_ex = 1; s.rf_ex = 1; s.rd_ex = 7; s.rm_id = 7; s.use_rm = 1;
        applyStimulus(s);
        s = idleStim();
        repeat (3) applyStimulus(s);

        s.branch_taken = 1; applyStimulus(s);
        s.branch_taken = 0; applyStimulus(s);
        s.mem_busy = 1;     repeat (4) applyStimulus(s);
        s.mem_busy = 0;     repeat (3) applyStimulus(s);

        s = idleStim();
        s.load_ex = 1; s.rf_ex = 1; s.rd_ex = 2; s.rd_id = 2; s.use_rd = 1;
        repeat (20) applyStimulus(s);
        s.clr_stats = 1; applyStimulus(s);
        s.clr_stats = 0; applyStimulus(s);

        s = idleStim();
        s.branch_taken = 1; applyStimulus(s);
        s.branch_taken = 0; applyStimulus(s);
        s.rst_n = 0;        repeat (2) applyStimulus(s);
        s.rst_n = 1;        repeat (2) applyStimulus(s);

        repeat (3000) applyStimulus(randStim());
        applyStimulus(idleStim());

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
